// File: rtl/queue_reader.sv
// Consumer-side controller for the 8-entry queue: pops one word at a time,
// presents it downstream with valid/ack, counts deliveries and flags ack timeouts.
module queue_reader #(
    parameter int DATA_W      = 8,
    parameter int LEN_W       = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk_10khz,
    input  logic              reset,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ack_in,
    output logic              busy_out,
    output logic [7:0]        count_out,
    output logic              timeout_out,
    output logic [1:0]        state_out
);

    // Downstream handshake: data_out is valid while valid_out=1 and is held stable
    // until the edge where ack_in=1 (transfer) or the ack timeout expires (drop).
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_POP     = 2'd1,
        S_WAIT    = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    localparam int TMO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (ACK_TIMEOUT != 0);

    state_t            state;
    state_t            next_state;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_cnt_d;
    logic              dequeue_d;
    logic [DATA_W-1:0] data_d;
    logic              valid_d;
    logic              busy_d;
    logic [7:0]        count_d;
    logic              timeout_d;
    logic              have_data;
    logic              ack_seen;
    logic              tmo_hit;
    logic              release_word;

    assign have_data    = (len_in != '0);
    assign ack_seen     = (state == S_PRESENT) && ack_in;
    // Ack on the expiry edge takes priority, so the timeout only fires without ack.
    assign tmo_hit      = TMO_EN && (state == S_PRESENT) && !ack_in && (tmo_cnt == TMO_LAST);
    assign release_word = ack_seen || tmo_hit;
    assign state_out    = state;

    always_ff @(posedge clk_10khz) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (have_data) next_state = S_POP;
            end
            S_POP: begin
                next_state = S_WAIT;
            end
            S_WAIT: begin
                next_state = S_PRESENT;
            end
            S_PRESENT: begin
                if (release_word) next_state = have_data ? S_POP : S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        dequeue_d = (next_state == S_POP);
        busy_d    = (next_state != S_IDLE);
        valid_d   = (next_state == S_PRESENT);
        data_d    = data_out;
        count_d   = count_out;
        timeout_d = timeout_out | tmo_hit;
        tmo_cnt_d = tmo_cnt;
        if (state == S_WAIT) begin
            data_d    = data_in;
            tmo_cnt_d = '0;
        end
        if (ack_seen) begin
            count_d = count_out + 8'd1;
        end else if (state == S_PRESENT) begin
            tmo_cnt_d = tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_10khz) begin
        if (reset) begin
            dequeue_out <= 1'b0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            busy_out    <= 1'b0;
            count_out   <= '0;
            timeout_out <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            dequeue_out <= dequeue_d;
            data_out    <= data_d;
            valid_out   <= valid_d;
            busy_out    <= busy_d;
            count_out   <= count_d;
            timeout_out <= timeout_d;
            tmo_cnt     <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_queue_reader.sv
// Bench for queue_reader: a behavioural 8-entry queue feeds the DUT and a
// scoreboard checks every presented word against the order it was enqueued.
module tb_queue_reader;

    localparam int DATA_W      = 8;
    localparam int LEN_W       = 4;
    localparam int ACK_TIMEOUT = 16;

    logic              clk_10khz = 1'b0;
    logic              reset     = 1'b1;
    logic              ack_in    = 1'b0;
    logic [LEN_W-1:0]  len_in    = '0;
    logic [DATA_W-1:0] data_in   = '0;
    logic              dequeue_out;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              busy_out;
    logic [7:0]        count_out;
    logic              timeout_out;
    logic [1:0]        state_out;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] push_q[$];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  exp_count   = '0;

    queue_reader #(
        .DATA_W(DATA_W),
        .LEN_W(LEN_W),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk_10khz(clk_10khz),
        .reset(reset),
        .len_in(len_in),
        .data_in(data_in),
        .dequeue_out(dequeue_out),
        .data_out(data_out),
        .valid_out(valid_out),
        .ack_in(ack_in),
        .busy_out(busy_out),
        .count_out(count_out),
        .timeout_out(timeout_out),
        .state_out(state_out)
    );

    // clock
    always #5 clk_10khz = ~clk_10khz;

    // queue model: registered data_out shows the popped word after a dequeue edge
    always @(posedge clk_10khz) begin
        if (dequeue_out === 1'b1 && model_q.size() != 0) data_in <= model_q.pop_front();
        while (push_q.size() != 0 && model_q.size() < 8) model_q.push_back(push_q.pop_front());
        len_in <= LEN_W'(model_q.size());
    end

    // scoreboard monitor, sampled on the falling edge
    logic             prev_deq   = 1'b0;
    logic             prev_valid = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [DATA_W-1:0] exp_word;

    always @(negedge clk_10khz) begin
        if (reset !== 1'b1) begin
            if (dequeue_out === 1'b1) begin
                vectors++;
                if (prev_deq || len_in == '0) begin
                    miscompares++;
                    $display("FAIL dequeue_pulse: prev_dequeue=%0b len_in=%0d, required isolated pulse with len_in!=0",
                             prev_deq, len_in);
                end
            end
            if (valid_out === 1'b1 && !prev_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL word_unexpected: data_out=%h presented, required no word", data_out);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (data_out !== exp_word) begin
                        miscompares++;
                        $display("FAIL word_data: data_out=%h, required %h", data_out, exp_word);
                    end
                end
            end else if (valid_out === 1'b1 && prev_valid) begin
                vectors++;
                if (data_out !== prev_data) begin
                    miscompares++;
                    $display("FAIL data_stable: data_out=%h, required held %h", data_out, prev_data);
                end
            end
            prev_deq   = (dequeue_out === 1'b1);
            prev_valid = (valid_out === 1'b1);
            prev_data  = data_out;
        end else begin
            prev_deq   = 1'b0;
            prev_valid = 1'b0;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk_10khz);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        push_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (valid_out !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_valid_wait: valid_out=%b after %0d cycles, required 1", name, valid_out, n);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        ack_in = 1'b0;
        repeat (3) step();
        vectors += 7;
        if (dequeue_out !== 1'b0) begin miscompares++; $display("FAIL rst_dequeue: got %b, required 0", dequeue_out); end
        if (data_out !== '0) begin miscompares++; $display("FAIL rst_data: got %h, required 00", data_out); end
        if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, required 0", valid_out); end
        if (busy_out !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy_out); end
        if (count_out !== 8'd0) begin miscompares++; $display("FAIL rst_count: got %0d, required 0", count_out); end
        if (timeout_out !== 1'b0) begin miscompares++; $display("FAIL rst_timeout: got %b, required 0", timeout_out); end
        if (state_out !== 2'd0) begin miscompares++; $display("FAIL rst_state: got %0d, required 0", state_out); end
        reset = 1'b0;
        step();
        exp_count = '0;
    endtask

    task automatic test_single();
        int n;
        push_word(8'hA5);
        n = 0;
        while (dequeue_out !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        vectors += 2;
        if (dequeue_out !== 1'b1) begin miscompares++; $display("FAIL single_pop: dequeue_out=%b, required 1", dequeue_out); end
        if (busy_out !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b, required 1", busy_out); end
        step();
        vectors += 2;
        if (dequeue_out !== 1'b0) begin miscompares++; $display("FAIL single_pulse_end: got %b, required 0", dequeue_out); end
        if (valid_out !== 1'b0) begin miscompares++; $display("FAIL single_wait_valid: got %b, required 0", valid_out); end
        step();
        vectors += 2;
        if (valid_out !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b, required 1", valid_out); end
        if (data_out !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h, required a5", data_out); end
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        exp_count++;
        vectors += 3;
        if (valid_out !== 1'b0) begin miscompares++; $display("FAIL single_valid_drop: got %b, required 0", valid_out); end
        if (count_out !== exp_count) begin miscompares++; $display("FAIL single_count: got %0d, required %0d", count_out, exp_count); end
        if (state_out !== 2'd0) begin miscompares++; $display("FAIL single_idle: state=%0d, required 0", state_out); end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (dequeue_out !== 1'b0) begin miscompares++; $display("FAIL single_no_pop: got %b, required 0", dequeue_out); end
        end
    endtask

    task automatic test_drain();
        int pulses;
        int last;
        logic [DATA_W-1:0] words [8];
        words[0] = 8'hA5;
        for (int i = 1; i < 8; i++) words[i] = DATA_W'(i + 1);
        ack_in = 1'b1;
        for (int i = 0; i < 8; i++) push_word(words[i]);
        pulses = 0;
        last   = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            step();
            if (dequeue_out === 1'b1) begin
                pulses++;
                if (pulses > 1) begin
                    vectors++;
                    if (cyc - last != 3) begin
                        miscompares++;
                        $display("FAIL drain_spacing: pulse gap %0d cycles, required 3", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        ack_in = 1'b0;
        exp_count += 8'd8;
        vectors += 3;
        if (pulses != 8) begin miscompares++; $display("FAIL drain_pulses: got %0d, required 8", pulses); end
        if (count_out !== exp_count) begin miscompares++; $display("FAIL drain_count: got %0d, required %0d", count_out, exp_count); end
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL drain_delivered: %0d words left, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int cnt;
        ack_in = 1'b0;
        push_word(8'h5C);
        wait_valid("bp");
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (valid_out === 1'b1) cnt++;
            step();
        end
        ack_in = 1'b1;
        if (valid_out === 1'b1) cnt++;
        step();
        ack_in = 1'b0;
        exp_count++;
        vectors += 4;
        if (valid_out !== 1'b0) begin miscompares++; $display("FAIL bp_valid_drop: got %b, required 0", valid_out); end
        if (cnt != 6) begin miscompares++; $display("FAIL bp_valid_cycles: got %0d, required 6", cnt); end
        if (count_out !== exp_count) begin miscompares++; $display("FAIL bp_count: got %0d, required %0d", count_out, exp_count); end
        if (timeout_out !== 1'b0) begin miscompares++; $display("FAIL bp_timeout: got %b, required 0", timeout_out); end
    endtask

    task automatic test_coincide();
        ack_in = 1'b0;
        push_word(8'hC3);
        wait_valid("coin");
        repeat (ACK_TIMEOUT - 1) step();
        vectors++;
        if (valid_out !== 1'b1) begin miscompares++; $display("FAIL coin_valid_16th: got %b, required 1", valid_out); end
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        exp_count++;
        vectors += 3;
        if (valid_out !== 1'b0) begin miscompares++; $display("FAIL coin_valid_drop: got %b, required 0", valid_out); end
        if (count_out !== exp_count) begin miscompares++; $display("FAIL coin_count: got %0d, required %0d", count_out, exp_count); end
        if (timeout_out !== 1'b0) begin miscompares++; $display("FAIL coin_timeout: got %b, required 0", timeout_out); end
    endtask

    task automatic test_timeout();
        int cnt;
        ack_in = 1'b0;
        push_word(8'h3E);
        wait_valid("tmo");
        cnt = 0;
        while (valid_out === 1'b1 && cnt < 40) begin
            cnt++;
            step();
        end
        vectors += 3;
        if (cnt != ACK_TIMEOUT) begin miscompares++; $display("FAIL tmo_valid_cycles: got %0d, required %0d", cnt, ACK_TIMEOUT); end
        if (timeout_out !== 1'b1) begin miscompares++; $display("FAIL tmo_flag: got %b, required 1", timeout_out); end
        if (count_out !== exp_count) begin miscompares++; $display("FAIL tmo_count: got %0d, required %0d", count_out, exp_count); end
        push_word(8'h11);
        wait_valid("tmo_next");
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        exp_count++;
        vectors += 2;
        if (count_out !== exp_count) begin miscompares++; $display("FAIL tmo_next_count: got %0d, required %0d", count_out, exp_count); end
        if (timeout_out !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky: got %b, required 1", timeout_out); end
    endtask

    task automatic test_reset_mid();
        ack_in = 1'b0;
        push_word(8'h77);
        wait_valid("rmid");
        vectors++;
        if (data_out !== 8'h77) begin miscompares++; $display("FAIL rmid_data: got %h, required 77", data_out); end
        repeat (2) step();
        push_word(8'h99);
        reset = 1'b1;
        step();
        exp_count = '0;
        vectors += 5;
        if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b, required 0", valid_out); end
        if (count_out !== 8'd0) begin miscompares++; $display("FAIL rmid_count: got %0d, required 0", count_out); end
        if (timeout_out !== 1'b0) begin miscompares++; $display("FAIL rmid_timeout: got %b, required 0", timeout_out); end
        if (busy_out !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b, required 0", busy_out); end
        if (dequeue_out !== 1'b0) begin miscompares++; $display("FAIL rmid_dequeue: got %b, required 0", dequeue_out); end
        reset = 1'b0;
        step();
        vectors++;
        if (dequeue_out !== 1'b1) begin miscompares++; $display("FAIL rmid_repop: got %b, required 1", dequeue_out); end
        repeat (2) step();
        vectors += 2;
        if (valid_out !== 1'b1) begin miscompares++; $display("FAIL rmid_next_valid: got %b, required 1", valid_out); end
        if (data_out !== 8'h99) begin miscompares++; $display("FAIL rmid_next_data: got %h, required 99", data_out); end
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        exp_count++;
        vectors++;
        if (count_out !== exp_count) begin miscompares++; $display("FAIL rmid_next_count: got %0d, required %0d", count_out, exp_count); end
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_drain();
        test_backpressure();
        test_coincide();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/queue_reader.md
# queue_reader

Consumer-side controller for the 8-entry `queue` in the 10 kHz clock domain. It watches the queue occupancy and issues single-cycle dequeue pulses. It captures each popped word and presents it downstream with a valid/ack handshake. It also counts delivered words and flags downstream stalls that exceed a programmable timeout.

## Interface
- `DATA_W`, 8, width of queue words.
- `LEN_W`, 4, width of queue occupancy (matches queue `len_out`).
- `ACK_TIMEOUT`, 16, cycles `valid_out` may stay high without `ack_in` before the word is dropped; 0 disables the timeout.
- `clk_10khz`  in  1  system clock (10 kHz); all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `len_in`  in  LEN_W  queue occupancy (queue `len_out`).
- `data_in`  in  DATA_W  queue head data (queue `data_out`).
- `dequeue_out`  out  1  one-cycle pop request to queue `dequeue_in`.
- `data_out`  out  DATA_W  word presented downstream.
- `valid_out`  out  1  `data_out` valid; held until ack or timeout.
- `ack_in`  in  1  downstream accept; sampled only while `valid_out`=1.
- `busy_out`  out  1  high in any state other than IDLE.
- `count_out`  out  8  delivered (acked) word count; wraps 255->0.
- `timeout_out`  out  1  sticky: at least one word dropped by timeout; cleared only by `reset`.

## Operation
- All outputs are registered.
- Reset values: `dequeue_out`=0, `data_out`=0, `valid_out`=0, `busy_out`=0, `count_out`=0, `timeout_out`=0, state IDLE, timeout counter 0.
- FSM states: IDLE, POP, WAIT, PRESENT.
- IDLE: if `len_in`!=0, go to POP and drive `dequeue_out`=1. Otherwise stay.
- POP: `dequeue_out` is high for exactly this one cycle. The queue removes its head at the closing edge. Next state is WAIT, and `dequeue_out` returns to 0.
- WAIT: one cycle so the queue's registered `data_out` settles. At the closing edge, capture `data_in` into `data_out`, set `valid_out`=1, clear the timeout counter, and go to PRESENT.
- PRESENT: `data_out` is held stable.
  - Edge with `ack_in`=1: `valid_out`=0 and `count_out`+1 (mod 256).
    - If `len_in`!=0 at that edge, go directly to POP (`dequeue_out`=1 next cycle).
    - Otherwise go to IDLE.
  - Edge with `ack_in`=0: the timeout counter increments. When `ACK_TIMEOUT`!=0 and the counter reaches `ACK_TIMEOUT`-1:
    - `valid_out`=0 and `timeout_out`=1; the word is discarded.
    - `count_out` is not incremented.
    - Next state follows the same rule as ack (POP if `len_in`!=0, else IDLE).
  - `ack_in` and timeout on the same edge: ack wins, so the word counts as delivered and `timeout_out` is unchanged.
- `ack_in` outside PRESENT is ignored.
- The block never issues `dequeue_out` while `len_in`==0, so the queue never sees an underflow pop.
- Only one word is in flight at a time. No second pop occurs until the current word is acked or dropped.
- Reset mid-operation (any state) returns to reset values on the next edge. A word already popped but not acked is lost by design.

## Timing
- Latency from IDLE with `len_in`!=0 sampled at edge E0:
  - `dequeue_out` high during cycle E0–E1.
  - `valid_out` rises at E2.
- Minimum period per word is 3 cycles: POP, WAIT, and PRESENT with immediate ack. Back-to-back delivery is 1 word per 3 cycles while the queue is non-empty.
- `dequeue_out` width is always exactly 1 cycle.
- Timeout: with no ack, `valid_out` is high for exactly `ACK_TIMEOUT` cycles (16 by default).
- `count_out` and `timeout_out` update on the same edge that drops `valid_out`.

## Test plan
- Reset, then single word: drive queue with A5 (`len_in` 0->1) and ack at the first valid edge. Required: one `dequeue_out` pulse, `valid_out` 2 cycles after the pulse, `data_out`=A5, `count_out`=1, FSM back to IDLE, `dequeue_out` stays 0 with `len_in`=0.
- Drain full queue: preload 8 words (A5, 02..08) with `ack_in` tied high. Required: eight pulses spaced 3 cycles apart, `data_out` sequence A5,02,...,08, `count_out`=8, no pop after `len_in` reaches 0.
- Backpressure: one word 5C, `ack_in` low for 5 cycles then high. Required: `valid_out` high 6 cycles, `data_out` stable 5C, `count_out`+1, `timeout_out`=0.
- Timeout (`ACK_TIMEOUT`=16): one word 3E, `ack_in` never asserted. Required: `valid_out` high exactly 16 cycles then drops, `timeout_out`=1 and stays 1 through later successful transfers, `count_out` unchanged.
- Ack/timeout coincidence: `ack_in` asserted on the 16th valid cycle. Required: counted as delivered, `timeout_out`=0.
- Reset mid-transfer: assert `reset` for 1 cycle while in PRESENT with word 77. Required: next edge gives `valid_out`=0, `count_out`=0, `timeout_out`=0, `busy_out`=0. After release with `len_in`!=0, a new pop is issued 1 cycle later.
